mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 16-bit processor.
- Holds a simple req/done handshake with each requester and sequences each memory access through issue, wait and complete states.
- Drives the stall flags back to the pipeline.
- Blocks new fetches after halt so the final memory dump sees a quiescent memory.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// The state/grant constants are plain localparams so that older code can keep using them.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int CNT_W = 4;

  // Attributes of the access currently in flight, latched at grant.
  typedef struct packed {
    logic gnt;
    logic wr;
    logic err;
  } accFlags_t;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times the fixed memory latency.
// It holds at zero instead of wrapping, so a stray dec cannot restart a wait.
module lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] countReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadVal;
    end else if (dec && (countReg != '0)) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign zero = (countReg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Only one access is in flight at a time; data requests win over fetches.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              dm_err,
  input  logic              halt,
  output logic              halt_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  logic [1:0]        stateReg, stateNext;
  accFlags_t         flagsReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] ifRdataReg, dmRdataReg;
  logic              haltSeenReg;
  logic              cntZero;
  logic              ifEligible, startAcc;
  logic              isIssue, isWait, isDone, captureNow;

  // Once halt has been seen, fetches are frozen so the final memory dump sees no traffic.
  assign ifEligible = if_req & ~haltSeenReg;
  assign startAcc   = (stateReg == IDLE) & (dm_req | ifEligible);
  assign isIssue    = (stateReg == ISSUE);
  assign isWait     = (stateReg == WAIT);
  assign isDone     = (stateReg == DONE);
  assign captureNow = isWait & cntZero;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (dm_req) begin
          stateNext = dm_addr[0] ? DONE : ISSUE;
        end else if (ifEligible) begin
          stateNext = ISSUE;
        end
      end
      ISSUE:   stateNext = WAIT;
      WAIT:    stateNext = cntZero ? DONE : WAIT;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg    <= IDLE;
      flagsReg    <= '0;
      addrReg     <= '0;
      wdataReg    <= '0;
      haltSeenReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (halt) begin
        haltSeenReg <= 1'b1;
      end
      if (startAcc) begin
        flagsReg.gnt <= dm_req ? GNT_DM : GNT_IF;
        flagsReg.wr  <= dm_req & dm_wr;
        flagsReg.err <= dm_req & dm_addr[0];
        addrReg      <= dm_req ? dm_addr : if_addr;
        wdataReg     <= dm_req ? dm_wdata : '0;
      end
    end
  end

  // Read data is captured on the last WAIT cycle and held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifRdataReg <= '0;
      dmRdataReg <= '0;
    end else if (captureNow) begin
      if (flagsReg.gnt == GNT_IF) begin
        ifRdataReg <= mem_rdata;
      end else if (!flagsReg.wr) begin
        dmRdataReg <= mem_rdata;
      end
    end
  end

  lat_counter uLatCounter (
    .clk     (clk),
    .rst     (rst),
    .load    (isIssue),
    .loadVal (LAT_LOAD),
    .dec     (isWait),
    .zero    (cntZero)
  );

  assign mem_en    = isIssue;
  assign mem_wr    = isIssue & flagsReg.wr;
  assign mem_addr  = isIssue ? addrReg : '0;
  assign mem_wdata = isIssue ? wdataReg : '0;

  assign if_done  = isDone & (flagsReg.gnt == GNT_IF);
  assign dm_done  = isDone & (flagsReg.gnt == GNT_DM);
  assign dm_err   = isDone & flagsReg.err;
  assign if_rdata = ifRdataReg;
  assign dm_rdata = dmRdataReg;

  // Stalls are forced low during reset so every output reads zero while rst is held.
  assign if_stall = rst & if_req & ~if_done;
  assign dm_stall = rst & dm_req & ~dm_done;
  assign halt_ack = haltSeenReg & (stateReg == IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, halt/reset sequences, and a
// randomized run checked against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, dm_err, halt_ack, mem_en, mem_wr;

  int passCnt = 0;
  int checkCnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall), .dm_err(dm_err),
    .halt(halt), .halt_ack(halt_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory model: data valid exactly LAT cycles after mem_en ----------------
  logic [15:0] memArr [logic [15:0]];
  logic [15:0] refMem [logic [15:0]];
  logic        pipeV [LAT];
  logic [15:0] pipeD [LAT];

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    if (refMem.exists(a)) return refMem[a];
    return a ^ 16'h5A3C;
  endfunction

  initial begin : memModel
    logic        cmdV;
    logic [15:0] cmdD;
    for (int i = 0; i < LAT; i++) begin
      pipeV[i] = 1'b0;
      pipeD[i] = 16'h0;
    end
    mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      cmdV = mem_en && !mem_wr;
      cmdD = 16'h0;
      if (mem_en && mem_wr) memArr[mem_addr] = mem_wdata;
      if (cmdV) cmdD = memRead(mem_addr);
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
        pipeV[i] = pipeV[i-1];
        pipeD[i] = pipeD[i-1];
      end
      pipeV[0] = cmdV;
      pipeD[0] = cmdD;
      mem_rdata = pipeV[LAT-1] ? pipeD[LAT-1] : 16'hDEAD;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    if_req = 1'b0; if_addr = 16'h0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    halt = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        dmReq;
    logic        dmWr;
    logic [15:0] dmAddr;
    logic [15:0] dmWdata;
    int          expIfLat;
    int          expDmLat;
    logic [15:0] expIfRdata;
    logic [15:0] expDmRdata;
    logic        expErr;
    int          expEnCnt;
    int          expEnCyc;
    logic        expMemWr;
    logic [15:0] expMemAddr;
    logic [15:0] expMemWdata;
  } vec_t;

  task automatic runVectors();
    vec_t        vecs [6];
    int          cyc, ifLat, dmLat, enCnt, enCyc, ifStall, dmStall;
    logic        enWr, errAtDone, sawIf, sawDm;
    logic [15:0] enAddr, enWdata, ifRd, dmRd;
    string       tag;
    vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, LAT+2, -1,
                16'hC123, 16'h0000, 1'b0, 1, 1, 1'b0, 16'h0010, 16'h0000};
    vecs[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 16'h0100, 16'h0000, 2*LAT+5, LAT+2,
                16'h7002, 16'hBEEF, 1'b0, 2, 1, 1'b0, 16'h0100, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, -1, LAT+2,
                16'h7002, 16'hBEEF, 1'b0, 1, 1, 1'b1, 16'h0200, 16'h1234};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0201, 16'h0000, -1, 1,
                16'h7002, 16'hBEEF, 1'b1, 0, -1, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, -1, LAT+2,
                16'h7002, 16'h1234, 1'b0, 1, 1, 1'b0, 16'h0200, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0203, 16'hFFFF, -1, 1,
                16'h7002, 16'h1234, 1'b1, 0, -1, 1'b0, 16'h0000, 16'h0000};
    for (int v = 0; v < 6; v++) begin
      if_req = vecs[v].ifReq; if_addr = vecs[v].ifAddr;
      dm_req = vecs[v].dmReq; dm_wr = vecs[v].dmWr;
      dm_addr = vecs[v].dmAddr; dm_wdata = vecs[v].dmWdata;
      cyc = 0; ifLat = -1; dmLat = -1; enCnt = 0; enCyc = -1; ifStall = 0; dmStall = 0;
      enWr = 1'b0; enAddr = 16'h0; enWdata = 16'h0; errAtDone = 1'b0; ifRd = 16'h0; dmRd = 16'h0;
      while (cyc < 40 && !((!vecs[v].ifReq || ifLat >= 0) && (!vecs[v].dmReq || dmLat >= 0))) begin
        @(negedge clk);
        sawIf = if_done;
        sawDm = dm_done;
        if (mem_en) begin
          enCnt++;
          if (enCyc < 0) begin
            enCyc = cyc; enWr = mem_wr; enAddr = mem_addr; enWdata = mem_wdata;
          end
        end
        if (if_stall) ifStall++;
        if (dm_stall) dmStall++;
        if (if_done) begin ifLat = cyc; ifRd = if_rdata; end
        if (dm_done) begin dmLat = cyc; dmRd = dm_rdata; errAtDone = dm_err; end
        tick();
        if (sawIf) if_req = 1'b0;
        if (sawDm) dm_req = 1'b0;
        cyc++;
      end
      if_req = 1'b0; dm_req = 1'b0;
      tag = $sformatf("vec%0d", v);
      check({tag, "_if_lat"}, ifLat, vecs[v].expIfLat);
      check({tag, "_dm_lat"}, dmLat, vecs[v].expDmLat);
      check({tag, "_en_cnt"}, enCnt, vecs[v].expEnCnt);
      check({tag, "_en_cyc"}, enCyc, vecs[v].expEnCyc);
      check({tag, "_if_stall_cyc"}, ifStall, vecs[v].ifReq ? vecs[v].expIfLat : 0);
      check({tag, "_dm_stall_cyc"}, dmStall, vecs[v].dmReq ? vecs[v].expDmLat : 0);
      if (vecs[v].ifReq) check({tag, "_if_rdata_at_done"}, ifRd, vecs[v].expIfRdata);
      if (vecs[v].dmReq) begin
        check({tag, "_dm_rdata_at_done"}, dmRd, vecs[v].expDmRdata);
        check({tag, "_dm_err"}, errAtDone, vecs[v].expErr);
      end
      if (vecs[v].expEnCyc >= 0) begin
        check({tag, "_mem_wr"}, enWr, vecs[v].expMemWr);
        check({tag, "_mem_addr"}, enAddr, vecs[v].expMemAddr);
        if (vecs[v].expMemWr) check({tag, "_mem_wdata"}, enWdata, vecs[v].expMemWdata);
      end
      check({tag, "_if_rdata_held"}, if_rdata, vecs[v].expIfRdata);
      check({tag, "_dm_rdata_held"}, dm_rdata, vecs[v].expDmRdata);
      $display("vector %0d: ifLat=%0d dmLat=%0d memEn=%0d err=%0b", v, ifLat, dmLat, enCnt, errAtDone);
    end
  endtask

  // ---------------- reset in the middle of WAIT ----------------
  task automatic runResetSeq();
    int doneCnt, enCnt;
    if_req = 1'b1; if_addr = 16'h0010;
    repeat (3) tick();
    rst = 1'b0;
    if_req = 1'b0;
    #1;
    check("rst_mid_rdata", {if_rdata, dm_rdata}, 32'h0);
    check("rst_mid_mem", {mem_addr, mem_wdata}, 32'h0);
    check("rst_mid_flags", {if_done, if_stall, dm_done, dm_stall, dm_err, halt_ack, mem_en, mem_wr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    doneCnt = 0; enCnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if_done || dm_done) doneCnt++;
      if (mem_en) enCnt++;
      tick();
    end
    check("rst_abandoned_done", doneCnt, 0);
    check("rst_abandoned_en", enCnt, 0);
    $display("reset mid-WAIT: doneAfter=%0d memEnAfter=%0d", doneCnt, enCnt);
  endtask

  // ---------------- halt arriving during a fetch ----------------
  task automatic runHaltSeq();
    int          lat, blocked, ackLow;
    logic [15:0] rd;
    logic        seen;
    if_req = 1'b1; if_addr = 16'h0010;
    lat = -1; rd = 16'h0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      halt = (k == 3);
      @(negedge clk);
      if (if_done) begin lat = k; rd = if_rdata; end
      tick();
    end
    halt = 1'b0; if_req = 1'b0;
    check("halt_fetch_lat", lat, LAT + 2);
    check("halt_fetch_rdata", rd, 16'hC123);
    @(negedge clk);
    check("halt_ack_first_idle", halt_ack, 1'b1);
    tick();
    if_req = 1'b1; if_addr = 16'h0012;
    blocked = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!mem_en && !if_done && halt_ack && if_stall) blocked++;
      tick();
    end
    check("halt_if_blocked_cycles", blocked, 10);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
    lat = -1; ackLow = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!halt_ack) ackLow++;
      seen = dm_done;
      if (dm_done) begin lat = k; rd = dm_rdata; end
      tick();
      if (seen) dm_req = 1'b0;
    end
    check("halt_dm_lat", lat, LAT + 2);
    check("halt_dm_rdata", rd, 16'hBEEF);
    check("halt_ack_low_cycles", ackLow, LAT + 2);
    $display("halt sequence: ifBlocked=%0d dmLat=%0d ackLow=%0d", blocked, lat, ackLow);
    idleInputs();
    pulseReset();
  endtask

  // ---------------- randomized run vs. timeline reference model ----------------
  task automatic runRandom(input int nCycles);
    int          freeCyc, doneCyc, enCyc, nIf, nDm;
    logic        mGnt, mErr, mWr, mHalt, eIf, eDm, eErr, eEn, eIdle, dropIf, dropDm;
    logic [15:0] mAddr, mWdata, mRd, expIfRd, expDmRd;
    refMem = memArr;
    freeCyc = 0; doneCyc = -1; enCyc = -1; nIf = 0; nDm = 0;
    mGnt = 1'b0; mErr = 1'b0; mWr = 1'b0; mHalt = 1'b0;
    mAddr = 16'h0; mWdata = 16'h0; mRd = 16'h0; expIfRd = 16'h0; expDmRd = 16'h0;
    dropIf = 1'b0; dropDm = 1'b0;
    for (int c = 0; c < nCycles; c++) begin
      if (dropIf) if_req = 1'b0;
      if (dropDm) dm_req = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = 16'($urandom_range(0, 31)) << 1;
      end
      if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1;
        dm_wr = 1'($urandom_range(0, 1));
        dm_addr = (16'($urandom_range(0, 31)) << 1) | 16'($urandom_range(0, 7) == 0);
        dm_wdata = 16'($urandom);
      end
      halt = (c > nCycles - 400) && ($urandom_range(0, 49) == 0);
      @(negedge clk);
      eIdle = (c >= freeCyc);
      eEn   = (c == enCyc);
      eIf   = (c == doneCyc) && (mGnt == 1'b0);
      eDm   = (c == doneCyc) && (mGnt == 1'b1);
      eErr  = (c == doneCyc) && mErr;
      if (eIf) expIfRd = mRd;
      if (eDm && !mWr && !mErr) expDmRd = mRd;
      check("rnd_mem_en", mem_en, eEn);
      check("rnd_if_done", if_done, eIf);
      check("rnd_dm_done", dm_done, eDm);
      check("rnd_dm_err", dm_err, eErr);
      check("rnd_if_rdata", if_rdata, expIfRd);
      check("rnd_dm_rdata", dm_rdata, expDmRd);
      check("rnd_halt_ack", halt_ack, mHalt && eIdle);
      check("rnd_stalls", {if_stall, dm_stall}, {if_req && !eIf, dm_req && !eDm});
      if (eEn) begin
        check("rnd_mem_wr", mem_wr, mWr);
        check("rnd_mem_addr", mem_addr, mAddr);
        if (mWr) check("rnd_mem_wdata", mem_wdata, mWdata);
      end
      if (eIf) nIf++;
      if (eDm) nDm++;
      if (eIdle && (dm_req || (if_req && !mHalt))) begin
        mGnt    = dm_req;
        mErr    = dm_req && dm_addr[0];
        mWr     = dm_req && dm_wr;
        mAddr   = dm_req ? dm_addr : if_addr;
        mWdata  = dm_wdata;
        doneCyc = c + (mErr ? 1 : LAT + 2);
        enCyc   = mErr ? -1 : c + 1;
        freeCyc = doneCyc + 1;
        if (!mErr) begin
          if (mWr) refMem[mAddr] = mWdata;
          else mRd = refRead(mAddr);
        end
      end
      if (halt) mHalt = 1'b1;
      dropIf = if_done;
      dropDm = dm_done;
      tick();
    end
    $display("random run: %0d cycles, %0d fetches, %0d data accesses, halted=%0b", nCycles, nIf, nDm, mHalt);
  endtask

  // ---------------- main ----------------
  initial begin
    idleInputs();
    rst = 1'b0;
    memArr[16'h0010] = 16'hC123;
    memArr[16'h0002] = 16'h7002;
    memArr[16'h0100] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", {if_rdata, dm_rdata}, 32'h0);
    check("reset_mem", {mem_addr, mem_wdata}, 32'h0);
    check("reset_flags", {if_done, if_stall, dm_done, dm_stall, dm_err, halt_ack, mem_en, mem_wr}, 32'h0);
    $display("reset state checked");
    rst = 1'b1;
    tick();
    runVectors();
    runResetSeq();
    runHaltSeq();
    runRandom(3000);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
